// File: rtl/comp_drain_sched.sv
// Picks the smallest of BPC/ZRL/SR per block, streams the winner's words and discards the losers' words.
// Latency: sizes ready at N -> size pop at N+1 -> first word valid at N+3 (header build COMP_SCHED_HDR_EN: payload +1).
// Backpressure: only the winner stalls, on ready_i low or an empty winner FIFO; loser discards never wait on ready_i.
module comp_drain_sched #(
    parameter int D_BITWIDTH   = 64,
    parameter int S_BITWIDTH   = 11,
    parameter int CNT_BITWIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bpc_s_empty,
    input  logic                    zrl_s_empty,
    input  logic                    sr_s_empty,
    input  logic [S_BITWIDTH-1:0]   bpc_s_data,
    input  logic [S_BITWIDTH-1:0]   zrl_s_data,
    input  logic                    sr_s_data,
    input  logic                    bpc_d_empty,
    input  logic                    zrl_d_empty,
    input  logic                    sr_d_empty,
    input  logic [D_BITWIDTH-1:0]   bpc_d_data,
    input  logic [D_BITWIDTH-1:0]   zrl_d_data,
    input  logic [D_BITWIDTH-1:0]   sr_d_data,
    output logic                    size_rd_o,
    output logic                    bpc_d_rd_o,
    output logic                    zrl_d_rd_o,
    output logic                    sr_d_rd_o,
    output logic [D_BITWIDTH-1:0]   data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    sop_o,
    output logic                    eop_o,
    output logic [1:0]              mode_o
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] MODE_BPC = 2'd0;
    localparam logic [1:0] MODE_ZRL = 2'd1;
    localparam logic [1:0] MODE_SR  = 2'd2;

    localparam logic [S_BITWIDTH:0]     SR_BITS = (S_BITWIDTH+1)'(64);
    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = CNT_BITWIDTH'(1);

    function automatic logic [CNT_BITWIDTH-1:0] words_of(input logic [S_BITWIDTH-1:0] bits);
        logic [S_BITWIDTH:0] sum;
        sum = {1'b0, bits} + (S_BITWIDTH+1)'(63);
        return CNT_BITWIDTH'(sum >> 6);
    endfunction

    logic [1:0]              state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [CNT_BITWIDTH-1:0] bpc_cnt_q, bpc_cnt_d, zrl_cnt_q, zrl_cnt_d, sr_cnt_q, sr_cnt_d;
    logic                    first_q, first_d;
    logic                    out_vld_q, out_vld_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [D_BITWIDTH-1:0]   out_dat_q, out_dat_d;

    logic [1:0]              sel_mode;
    logic [CNT_BITWIDTH-1:0] bpc_words, zrl_words, sr_words;
    logic [CNT_BITWIDTH-1:0] win_cnt;
    logic                    win_empty;
    logic [D_BITWIDTH-1:0]   win_dat;
    logic                    draining, out_free, hdr_busy, win_pop;
    logic                    bpc_lose, zrl_lose, sr_lose;

    // Later candidates replace on <=, which gives the SR > ZRL > BPC tie order.
    always_comb begin
        bpc_words = words_of(bpc_s_data);
        zrl_words = words_of(zrl_s_data);
        sr_words  = sr_s_data ? CNT_ONE : '0;
        sel_mode  = MODE_BPC;
        if (zrl_s_data <= bpc_s_data) sel_mode = MODE_ZRL;
        if (sr_s_data && SR_BITS <= {1'b0, bpc_s_data} && SR_BITS <= {1'b0, zrl_s_data})
            sel_mode = MODE_SR;
    end

`ifdef COMP_SCHED_HDR_EN
    logic                  hdr_pend_q, hdr_pend_d;
    logic [D_BITWIDTH-1:0] hdr_dat_q, hdr_dat_d;
    logic [S_BITWIDTH-1:0] sel_bits;
    assign sel_bits = (sel_mode == MODE_SR)  ? SR_BITS[S_BITWIDTH-1:0] :
                      (sel_mode == MODE_ZRL) ? zrl_s_data : bpc_s_data;
    assign hdr_busy = hdr_pend_q;
`else
    assign hdr_busy = 1'b0;
`endif

    always_comb begin
        win_cnt   = bpc_cnt_q;
        win_empty = bpc_d_empty;
        win_dat   = bpc_d_data;
        case (mode_q)
            MODE_ZRL: begin win_cnt = zrl_cnt_q; win_empty = zrl_d_empty; win_dat = zrl_d_data; end
            MODE_SR:  begin win_cnt = sr_cnt_q;  win_empty = sr_d_empty;  win_dat = sr_d_data;  end
            default: ;
        endcase
    end

    assign draining = (state_q == ST_DRAIN);
    assign out_free = !out_vld_q || ready_i;
    assign win_pop  = draining && !hdr_busy && (win_cnt != '0) && !win_empty && out_free;
    assign bpc_lose = draining && (mode_q != MODE_BPC) && (bpc_cnt_q != '0) && !bpc_d_empty;
    assign zrl_lose = draining && (mode_q != MODE_ZRL) && (zrl_cnt_q != '0) && !zrl_d_empty;
    assign sr_lose  = draining && (mode_q != MODE_SR)  && (sr_cnt_q  != '0) && !sr_d_empty;

    assign bpc_d_rd_o = (mode_q == MODE_BPC) ? win_pop : bpc_lose;
    assign zrl_d_rd_o = (mode_q == MODE_ZRL) ? win_pop : zrl_lose;
    assign sr_d_rd_o  = (mode_q == MODE_SR)  ? win_pop : sr_lose;
    assign size_rd_o  = (state_q == ST_SELECT);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        bpc_cnt_d = bpc_cnt_q;
        zrl_cnt_d = zrl_cnt_q;
        sr_cnt_d  = sr_cnt_q;
        first_d   = first_q;
        out_vld_d = out_vld_q;
        out_sop_d = out_sop_q;
        out_eop_d = out_eop_q;
        out_dat_d = out_dat_q;
`ifdef COMP_SCHED_HDR_EN
        hdr_pend_d = hdr_pend_q;
        hdr_dat_d  = hdr_dat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!bpc_s_empty && !zrl_s_empty && !sr_s_empty) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                mode_d    = sel_mode;
                bpc_cnt_d = bpc_words;
                zrl_cnt_d = zrl_words;
                sr_cnt_d  = sr_words;
                // A zero-length winner still owns one word in its data FIFO.
                case (sel_mode)
                    MODE_ZRL: if (zrl_words == '0) zrl_cnt_d = CNT_ONE;
                    MODE_SR:  sr_cnt_d = CNT_ONE;
                    default:  if (bpc_words == '0) bpc_cnt_d = CNT_ONE;
                endcase
`ifdef COMP_SCHED_HDR_EN
                first_d    = 1'b0;
                hdr_pend_d = 1'b1;
                hdr_dat_d  = '0;
                hdr_dat_d[1:0] = sel_mode;
                hdr_dat_d[2 +: S_BITWIDTH] = sel_bits;
`else
                first_d    = 1'b1;
`endif
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bpc_d_rd_o) bpc_cnt_d = bpc_cnt_q - CNT_ONE;
                if (zrl_d_rd_o) zrl_cnt_d = zrl_cnt_q - CNT_ONE;
                if (sr_d_rd_o)  sr_cnt_d  = sr_cnt_q - CNT_ONE;
                if (win_pop) begin
                    out_vld_d = 1'b1;
                    out_dat_d = win_dat;
                    out_sop_d = first_q;
                    out_eop_d = (win_cnt == CNT_ONE);
                    first_d   = 1'b0;
                end
`ifdef COMP_SCHED_HDR_EN
                else if (hdr_pend_q && out_free) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = hdr_dat_q;
                    out_sop_d  = 1'b1;
                    out_eop_d  = 1'b0;
                    hdr_pend_d = 1'b0;
                end
`endif
                else if (ready_i) begin
                    out_vld_d = 1'b0;
                end
                if (bpc_cnt_q == '0 && zrl_cnt_q == '0 && sr_cnt_q == '0 && out_free && !hdr_busy)
                    state_d = ST_DONE;
            end
            default: begin
                out_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_BPC;
            bpc_cnt_q <= '0;
            zrl_cnt_q <= '0;
            sr_cnt_q  <= '0;
            first_q   <= 1'b0;
            out_vld_q <= 1'b0;
            out_sop_q <= 1'b0;
            out_eop_q <= 1'b0;
            out_dat_q <= '0;
`ifdef COMP_SCHED_HDR_EN
            hdr_pend_q <= 1'b0;
            hdr_dat_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            bpc_cnt_q <= bpc_cnt_d;
            zrl_cnt_q <= zrl_cnt_d;
            sr_cnt_q  <= sr_cnt_d;
            first_q   <= first_d;
            out_vld_q <= out_vld_d;
            out_sop_q <= out_sop_d;
            out_eop_q <= out_eop_d;
            out_dat_q <= out_dat_d;
`ifdef COMP_SCHED_HDR_EN
            hdr_pend_q <= hdr_pend_d;
            hdr_dat_q  <= hdr_dat_d;
`endif
        end
    end

    assign data_o  = out_dat_q;
    assign valid_o = out_vld_q;
    assign sop_o   = out_sop_q;
    assign eop_o   = out_eop_q;
    assign mode_o  = mode_q;
endmodule

// File: tb/tb_comp_drain_sched.sv
// Bench for comp_drain_sched: FIFO models feed the DUT, a reference model queues expected words, a monitor checks them.
`timescale 1ns/1ps
module tb_comp_drain_sched;
    localparam int DW = 64;
    localparam int SW = 11;
`ifdef COMP_SCHED_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic clk, rst_n;
    logic bpc_s_empty, zrl_s_empty, sr_s_empty;
    logic [SW-1:0] bpc_s_data, zrl_s_data;
    logic sr_s_data;
    logic bpc_d_empty, zrl_d_empty, sr_d_empty;
    logic [DW-1:0] bpc_d_data, zrl_d_data, sr_d_data;
    logic size_rd_o, bpc_d_rd_o, zrl_d_rd_o, sr_d_rd_o;
    logic [DW-1:0] data_o;
    logic valid_o, ready_i, sop_o, eop_o;
    logic [1:0] mode_o;

    comp_drain_sched #(.D_BITWIDTH(DW), .S_BITWIDTH(SW), .CNT_BITWIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .bpc_s_empty(bpc_s_empty), .zrl_s_empty(zrl_s_empty), .sr_s_empty(sr_s_empty),
        .bpc_s_data(bpc_s_data), .zrl_s_data(zrl_s_data), .sr_s_data(sr_s_data),
        .bpc_d_empty(bpc_d_empty), .zrl_d_empty(zrl_d_empty), .sr_d_empty(sr_d_empty),
        .bpc_d_data(bpc_d_data), .zrl_d_data(zrl_d_data), .sr_d_data(sr_d_data),
        .size_rd_o(size_rd_o), .bpc_d_rd_o(bpc_d_rd_o), .zrl_d_rd_o(zrl_d_rd_o), .sr_d_rd_o(sr_d_rd_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .sop_o(sop_o), .eop_o(eop_o), .mode_o(mode_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dat;
        logic          sop;
        logic          eop;
        logic [1:0]    mode;
    } exp_t;

    exp_t          exp_q[$];
    logic [SW-1:0] bpc_sq[$], zrl_sq[$];
    logic          sr_sq[$];
    logic [DW-1:0] bpc_dq[$], zrl_dq[$], sr_dq[$], zrl_hold_q[$];

    int checks = 0, failures = 0, xfers = 0;
    int bpc_pops = 0, zrl_pops = 0, sr_pops = 0;
    int bpc_push = 0, zrl_push = 0, sr_push = 0;
    int ready_mode = 0;
    logic tog = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic refresh();
        bpc_s_empty = (bpc_sq.size() == 0);
        zrl_s_empty = (zrl_sq.size() == 0);
        sr_s_empty  = (sr_sq.size() == 0);
        bpc_s_data  = bpc_s_empty ? '0 : bpc_sq[0];
        zrl_s_data  = zrl_s_empty ? '0 : zrl_sq[0];
        sr_s_data   = sr_s_empty ? 1'b0 : sr_sq[0];
        bpc_d_empty = (bpc_dq.size() == 0);
        zrl_d_empty = (zrl_dq.size() == 0);
        sr_d_empty  = (sr_dq.size() == 0);
        bpc_d_data  = bpc_d_empty ? '0 : bpc_dq[0];
        zrl_d_data  = zrl_d_empty ? '0 : zrl_dq[0];
        sr_d_data   = sr_d_empty ? '0 : sr_dq[0];
        case (ready_mode)
            0: ready_i = 1'b1;
            1: begin tog = !tog; ready_i = tog; end
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    // FIFO models: pops sampled mid-cycle, applied at the edge, heads refreshed just after.
    logic l_size, l_b, l_z, l_s;
    always begin
        @(negedge clk);
        l_size = size_rd_o; l_b = bpc_d_rd_o; l_z = zrl_d_rd_o; l_s = sr_d_rd_o;
        @(posedge clk);
        if (rst_n) begin
            if (l_size && bpc_sq.size() > 0) void'(bpc_sq.pop_front());
            if (l_size && zrl_sq.size() > 0) void'(zrl_sq.pop_front());
            if (l_size && sr_sq.size() > 0)  void'(sr_sq.pop_front());
            if (l_b && bpc_dq.size() > 0) begin void'(bpc_dq.pop_front()); bpc_pops++; end
            if (l_z && zrl_dq.size() > 0) begin void'(zrl_dq.pop_front()); zrl_pops++; end
            if (l_s && sr_dq.size() > 0)  begin void'(sr_dq.pop_front());  sr_pops++;  end
        end
        #1;
        refresh();
    end

    // Monitor: output scoreboard, stall stability and no pops on empty FIFOs.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] p_dat;
    logic          p_sop, p_eop;
    logic [1:0]    p_mode;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (size_rd_o || bpc_d_rd_o || zrl_d_rd_o || sr_d_rd_o) begin
                checks++;
                if ((size_rd_o && (bpc_s_empty || zrl_s_empty || sr_s_empty)) ||
                    (bpc_d_rd_o && bpc_d_empty) || (zrl_d_rd_o && zrl_d_empty) || (sr_d_rd_o && sr_d_empty)) begin
                    failures++;
                    $display("FAIL rd_on_empty: rd s/b/z/r=%b%b%b%b empty b/z/r=%b%b%b", size_rd_o,
                             bpc_d_rd_o, zrl_d_rd_o, sr_d_rd_o, bpc_d_empty, zrl_d_empty, sr_d_empty);
                end
            end
            if (stall_prev) begin
                checks++;
                if (!valid_o || data_o !== p_dat || sop_o !== p_sop || eop_o !== p_eop || mode_o !== p_mode) begin
                    failures++;
                    $display("FAIL stall_stable: got v=%b dat=%h sop=%b eop=%b mode=%b want v=1 dat=%h sop=%b eop=%b mode=%b",
                             valid_o, data_o, sop_o, eop_o, mode_o, p_dat, p_sop, p_eop, p_mode);
                end
            end
            if (valid_o && ready_i) begin
                checks++;
                xfers++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got dat=%h sop=%b eop=%b mode=%b want nothing", data_o, sop_o, eop_o, mode_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (data_o !== e.dat || sop_o !== e.sop || eop_o !== e.eop || mode_o !== e.mode) begin
                        failures++;
                        $display("FAIL out_word: got dat=%h sop=%b eop=%b mode=%b want dat=%h sop=%b eop=%b mode=%b",
                                 data_o, sop_o, eop_o, mode_o, e.dat, e.sop, e.eop, e.mode);
                    end
                end
            end
            stall_prev = valid_o && !ready_i;
            p_dat = data_o; p_sop = sop_o; p_eop = eop_o; p_mode = mode_o;
        end
    end

    // Reference: the winner is the smallest key size*4+rank, rank SR=0 ZRL=1 BPC=2.
    task automatic push_block(input int bs, input int zs, input bit sf, input int zhold);
        int kb, kz, ks, key, wm, wbits, n;
        logic [DW-1:0] w;
        exp_t e;
        kb = bs * 4 + 2;
        kz = zs * 4 + 1;
        ks = sf ? 64 * 4 : 32'h3fff_ffff;
        key = kb;
        if (kz < key) key = kz;
        if (ks < key) key = ks;
        wm = (key == ks) ? 2 : (key == kz) ? 1 : 0;
        wbits = key / 4;
        if (HDR != 0) begin
            e.dat = (64'(wbits) << 2) | 64'(wm);
            e.sop = 1'b1; e.eop = 1'b0; e.mode = 2'(wm);
            exp_q.push_back(e);
        end
        for (int f = 0; f < 3; f++) begin
            n = (f == 0) ? (bs + 63) / 64 : (f == 1) ? (zs + 63) / 64 : (sf ? 1 : 0);
            if (f == wm && n == 0) n = 1;
            for (int i = 0; i < n; i++) begin
                w = {$urandom, $urandom};
                if (f == 0) begin bpc_dq.push_back(w); bpc_push++; end
                else if (f == 1) begin
                    if (i >= n - zhold) zrl_hold_q.push_back(w); else zrl_dq.push_back(w);
                    zrl_push++;
                end else begin sr_dq.push_back(w); sr_push++; end
                if (f == wm) begin
                    e.dat = w; e.sop = (i == 0) && (HDR == 0); e.eop = (i == n - 1); e.mode = 2'(wm);
                    exp_q.push_back(e);
                end
            end
        end
        bpc_sq.push_back(SW'(bs));
        zrl_sq.push_back(SW'(zs));
        sr_sq.push_back(sf);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            ok = exp_q.size() == 0 && bpc_dq.size() == 0 && zrl_dq.size() == 0 && sr_dq.size() == 0 &&
                 bpc_sq.size() == 0 && zrl_sq.size() == 0 && sr_sq.size() == 0 && !valid_o;
        end
        chk({name, "_drained"}, 64'(ok), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    // Issues a block into an idle DUT and measures cycles to the size pop and first valid word.
    task automatic latency_block(input string name, input int bs, input int zs, input bit sf);
        int srd, lat;
        srd = 0; lat = 0;
        @(negedge clk);
        push_block(bs, zs, sf, 0);
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            if (size_rd_o && srd == 0) srd = k;
            if (valid_o) lat = k;
        end
        chk({name, "_size_rd_cycle"}, 64'(srd), 64'd2);
        chk({name, "_first_valid_cycle"}, 64'(lat), 64'd4);
    endtask

    initial begin
        int b0, z0, s0, x0, nblk;
        bit hit;
        rst_n = 1'b0;
        refresh();
        repeat (3) @(negedge clk);
        chk("reset_data", data_o, 64'd0);
        chk("reset_ctrl", 64'({size_rd_o, bpc_d_rd_o, zrl_d_rd_o, sr_d_rd_o, valid_o, sop_o, eop_o, mode_o}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // BPC 130 wins with 3 words; ZRL 200 discards 4; SR not applicable.
        b0 = bpc_pops; z0 = zrl_pops; s0 = sr_pops; x0 = xfers;
        latency_block("t1", 130, 200, 1'b0);
        wait_idle("t1", 200);
        chk("t1_bpc_pops", 64'(bpc_pops - b0), 64'd3);
        chk("t1_zrl_pops", 64'(zrl_pops - z0), 64'd4);
        chk("t1_sr_pops", 64'(sr_pops - s0), 64'd0);
        chk("t1_xfers", 64'(xfers - x0), 64'(3 + HDR));

        // Three-way tie at 64 bits: SR wins a single-word block.
        b0 = bpc_pops; z0 = zrl_pops; s0 = sr_pops; x0 = xfers;
        push_block(64, 64, 1'b1, 0);
        wait_idle("t2", 200);
        chk("t2_bpc_pops", 64'(bpc_pops - b0), 64'd1);
        chk("t2_zrl_pops", 64'(zrl_pops - z0), 64'd1);
        chk("t2_sr_pops", 64'(sr_pops - s0), 64'd1);
        chk("t2_xfers", 64'(xfers - x0), 64'(1 + HDR));

        // ZRL 2047 wins the tie over BPC 2047, with ready toggling.
        ready_mode = 1;
        x0 = xfers;
        push_block(2047, 2047, 1'b0, 0);
        wait_idle("t3", 400);
        chk("t3_xfers", 64'(xfers - x0), 64'(32 + HDR));

        // Loser ZRL data held back mid-block; the following block must stay aligned.
        ready_mode = 0;
        x0 = xfers;
        @(negedge clk);
        push_block(130, 700, 1'b0, 8);
        repeat (8) @(negedge clk);
        chk("t4_winner_continues", 64'(xfers - x0), 64'(3 + HDR));
        while (zrl_hold_q.size() > 0) zrl_dq.push_back(zrl_hold_q.pop_front());
        push_block(300, 100, 1'b1, 0);
        wait_idle("t4", 300);
        chk("t4_xfers", 64'(xfers - x0), 64'(4 + 2 * HDR));

        // Reset in the middle of a 10-word block.
        x0 = xfers;
        push_block(600, 2000, 1'b0, 0);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            hit = (xfers - x0) >= 3;
        end
        chk("t5_reached_word4", 64'(hit), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_reset_data", data_o, 64'd0);
        chk("t5_reset_ctrl", 64'({size_rd_o, bpc_d_rd_o, zrl_d_rd_o, sr_d_rd_o, valid_o, sop_o, eop_o, mode_o}), 64'd0);
        exp_q.delete(); bpc_sq.delete(); zrl_sq.delete(); sr_sq.delete();
        bpc_dq.delete(); zrl_dq.delete(); sr_dq.delete(); zrl_hold_q.delete();
        bpc_pops = 0; zrl_pops = 0; sr_pops = 0; bpc_push = 0; zrl_push = 0; sr_push = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        latency_block("t5", 100, 300, 1'b0);
        wait_idle("t5", 200);

        // Random blocks, often back to back, with random ready.
        ready_mode = 2;
        nblk = 40;
        for (int b = 0; b < nblk; b++) begin
            int sz[2];
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 3))
                    0: sz[j] = 64;
                    1: sz[j] = $urandom_range(1, 128);
                    2: sz[j] = $urandom_range(1, 2047);
                    default: sz[j] = 2047;
                endcase
            end
            @(negedge clk);
            push_block(sz[0], sz[1], 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 2) == 0) wait_idle("rand", 400);
        end
        wait_idle("rand_final", 20000);
        chk("total_bpc_pops", 64'(bpc_pops), 64'(bpc_push));
        chk("total_zrl_pops", 64'(zrl_pops), 64'(zrl_push));
        chk("total_sr_pops", 64'(sr_pops), 64'(sr_push));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got no finish want finish within 2ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
